// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment front end: accepts a binary value, converts it to BCD with a
// sequenced double-dabble engine, and time-multiplexes the digits onto seg/an.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_value,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        ovf
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t             state;
  logic [15:0]        shift;
  logic [19:0]        bcd;
  logic [19:0]        bcd_adj;
  logic [3:0]         step;
  logic [3:0][3:0]    dig;
  logic [CW-1:0]      cnt;
  logic [1:0]         idx;
  logic [3:0]         vis;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b0111111;
      4'd1:    c = 7'b0000110;
      4'd2:    c = 7'b1011011;
      4'd3:    c = 7'b1001111;
      4'd4:    c = 7'b1100110;
      4'd5:    c = 7'b1101101;
      4'd6:    c = 7'b1111101;
      4'd7:    c = 7'b0000111;
      4'd8:    c = 7'b1111111;
      4'd9:    c = 7'b1101111;
      DASH:    c = 7'b1000000;
      default: c = 7'b0000000;
    endcase
    return c;
  endfunction

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bcd      <= '0;
      step     <= '0;
      dig      <= '0;
      ovf      <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift    <= in_value;
            bcd      <= '0;
            step     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          {bcd, shift} <= {bcd_adj[18:0], shift, 1'b0};
          step         <= step + 4'd1;
          if (step == 4'd15) state <= LOAD;
        end
        LOAD: begin
          if (bcd[19:16] != 4'd0) begin
            ovf <= 1'b1;
            dig <= {4{DASH}};
          end else begin
            ovf <= 1'b0;
            dig <= bcd[15:0];
          end
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Leading-zero blanking; digit 0 always visible, dash is nonzero so never blanked.
  always_comb begin
    vis[3] = (dig[3] != 4'd0);
    vis[2] = vis[3] | (dig[2] != 4'd0);
    vis[1] = vis[2] | (dig[1] != 4'd0);
    vis[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      seg <= enc(4'd0) ^ {7{SEG_ACTIVE_LOW}};
      an  <= 4'b0001 ^ {4{AN_ACTIVE_LOW}};
    end else begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      seg <= enc(dig[idx]) ^ {7{SEG_ACTIVE_LOW}};
      an  <= ((!blank && vis[idx]) ? (4'b0001 << idx) : 4'b0000) ^ {4{AN_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: table vectors, random values against a
// decimal-arithmetic model, and hand sequences for handshake, reset and blanking.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = '0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .blank(blank), .seg(seg), .an(an), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic            ovf;
    logic [3:0]      vis;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t tbl[8];

  localparam logic [6:0] L0 = 7'b1000000, L1 = 7'b1111001, L2 = 7'b0100100,
                         L3 = 7'b0110000, L4 = 7'b0011001, L7 = 7'b1111000,
                         L9 = 7'b0010000, LD = 7'b0111111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Active-low glyph for a decimal digit (10 = dash), from the display code table.
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] c;
    case (d)
      0: c = 7'b0111111; 1: c = 7'b0000110; 2: c = 7'b1011011; 3: c = 7'b1001111;
      4: c = 7'b1100110; 5: c = 7'b1101101; 6: c = 7'b1111101; 7: c = 7'b0000111;
      8: c = 7'b1111111; 9: c = 7'b1101111; default: c = 7'b1000000;
    endcase
    return ~c;
  endfunction

  task automatic model(input int v, output logic o, output logic [3:0] vis,
                       output logic [3:0][6:0] segs);
    int d[4];
    o = (v > 9999);
    for (int i = 0; i < 4; i++) d[i] = o ? 10 : (v / (10 ** i)) % 10;
    vis[3] = o || (d[3] != 0);
    vis[2] = vis[3] || (d[2] != 0);
    vis[1] = vis[2] || (d[1] != 0);
    vis[0] = 1'b1;
    for (int i = 0; i < 4; i++) segs[i] = glyph(d[i]);
  endtask

  // Watch the multiplexed outputs and require every visible digit to appear with
  // the right glyph, and no blanked digit to ever be enabled.
  task automatic scan_check(input string name, input logic [3:0] vis,
                            input logic [3:0][6:0] segs, input int nsamp);
    int seen[4];
    int bad = 0;
    int d;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    @(negedge clk);
    for (int n = 0; n < nsamp; n++) begin
      @(negedge clk);
      if (an != 4'b1111) begin
        d = -1;
        for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) d = i;
        if (d < 0) bad++;
        else begin
          seen[d]++;
          if (!vis[d]) bad++;
          else if (seg !== segs[d]) begin
            bad++;
            $display("FAIL %s_seg digit%0d actual=%b required=%b", name, d, seg, segs[d]);
          end
        end
      end
    end
    chk({name, "_scan_bad"}, bad, 0);
    for (int i = 0; i < 4; i++)
      if (vis[i]) chk($sformatf("%s_shown%0d", name, i), (seen[i] > 0), 1);
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int t = 0;
    ok = 1;
    while (!in_ready && t < 60) begin @(negedge clk); t++; end
    if (!in_ready) begin
      ok = 0;
      errors++; checks++;
      $display("FAIL %s_ready_timeout actual=0 required=1", name);
    end
  endtask

  task automatic do_transfer(input string name, input logic [15:0] v, input logic exp_ovf);
    bit ok;
    int bad = 0;
    @(negedge clk);
    wait_ready(name, ok);
    if (!ok) return;
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (!busy || in_ready) bad++;
    end
    chk({name, "_busy_span"}, bad, 0);
    @(negedge clk);
    chk({name, "_idle"}, {busy, in_ready}, 2'b01);
    chk({name, "_ovf"}, ovf, exp_ovf);
  endtask

  initial begin
    logic            mo;
    logic [3:0]      mv;
    logic [3:0][6:0] ms;
    int              v;
    bit              ok;
    int              bad;

    tbl[0] = '{16'd1234,  1'b0, 4'b1111, {L1, L2, L3, L4}};
    tbl[1] = '{16'd65535, 1'b1, 4'b1111, {LD, LD, LD, LD}};
    tbl[2] = '{16'd7,     1'b0, 4'b0001, {L0, L0, L0, L7}};
    tbl[3] = '{16'd9999,  1'b0, 4'b1111, {L9, L9, L9, L9}};
    tbl[4] = '{16'd0,     1'b0, 4'b0001, {L0, L0, L0, L0}};
    tbl[5] = '{16'd10000, 1'b1, 4'b1111, {LD, LD, LD, LD}};
    tbl[6] = '{16'd1000,  1'b0, 4'b1111, {L1, L0, L0, L0}};
    tbl[7] = '{16'd9,     1'b0, 4'b0001, {L0, L0, L0, L9}};

    repeat (2) @(negedge clk);
    chk("reset_an", an, 4'b1110);
    chk("reset_seg", seg, 7'b1000000);
    chk("reset_ovf_busy", {ovf, busy}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("release_ready", in_ready, 1'b1);
    scan_check("reset_disp", 4'b0001, {L0, L0, L0, L0}, 20);

    for (int i = 0; i < 8; i++) begin
      do_transfer($sformatf("vec%0d", i), tbl[i].value, tbl[i].ovf);
      scan_check($sformatf("vec%0d", i), tbl[i].vis, tbl[i].segs, 20);
    end

    // in_valid held high: 100 taken at T, 200 only at T+18.
    @(negedge clk);
    wait_ready("b2b", ok);
    in_valid = 1'b1;
    in_value = 16'd100;
    @(posedge clk);
    #1 in_value = 16'd200;
    bad = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (!busy || in_ready) bad++;
    end
    chk("b2b_busy_span", bad, 0);
    @(negedge clk);
    chk("b2b_gap", {busy, in_ready, ovf}, 3'b010);
    @(negedge clk);
    chk("b2b_second_accept", {busy, in_ready}, 2'b10);
    in_valid = 1'b0;
    scan_check("b2b_100", 4'b0111, {L0, L1, L0, L0}, 15);
    @(negedge clk);
    chk("b2b_done", {busy, in_ready, ovf}, 3'b010);
    scan_check("b2b_200", 4'b0111, {L0, L2, L0, L0}, 20);

    // Reset in the middle of converting 4321.
    @(negedge clk);
    wait_ready("rstmid", ok);
    in_valid = 1'b1;
    in_value = 16'd4321;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_state", {busy, in_ready, ovf}, 3'b010);
    chk("rstmid_an", an, 4'b1110);
    chk("rstmid_seg", seg, 7'b1000000);
    scan_check("rstmid_disp", 4'b0001, {L0, L0, L0, L0}, 20);
    do_transfer("after_rst", 16'd42, 1'b0);
    scan_check("after_rst", 4'b0011, {L0, L0, L4, L2}, 20);

    // Blanking.
    @(negedge clk);
    blank = 1'b1;
    @(negedge clk);
    chk("blank_an", an, 4'b1111);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (an != 4'b1111) bad++;
    end
    chk("blank_hold", bad, 0);
    blank = 1'b0;
    scan_check("unblank", 4'b0011, {L0, L0, L4, L2}, 20);

    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9999));
      model(v, mo, mv, ms);
      do_transfer($sformatf("rnd%0d_%0d", i, v), 16'(v), mo);
      scan_check($sformatf("rnd%0d_%0d", i, v), mv, ms, 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Front-end controller for the 4-digit 7-segment LED display.
- Accepts a 16-bit binary value over a valid/ready handshake.
- Converts it to BCD with a multi-cycle, sequenced shift-add-3 (double dabble) engine.
- Latches the result into a display register and time-multiplexes the four digits onto shared segment/anode lines.
- Sits between the value producer and the board pins.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit is driven before advancing; legal range >= 2
SEG_ACTIVE_LOW, 1, 1 = seg lit by 0; 0 = seg lit by 1
AN_ACTIVE_LOW, 1, 1 = anode enabled by 0; 0 = enabled by 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  in_value is valid
in_ready  out  1  controller can accept a value (high only in IDLE)
in_value  in  16  unsigned binary value to display
blank  in  1  when 1, all anodes disabled
seg  out  7  segments {g,f,e,d,c,b,a}, registered
an  out  4  digit enables, an[0] = least-significant digit, registered
busy  out  1  conversion in progress (CONV or LOAD)
ovf  out  1  displayed value was > 9999

Behaviour:
Reset (async, rst=1):
- FSM = IDLE; display digits = 0,0,0,0; ovf=0; scan counter=0; digit index=0.
- an = digit0 enabled (active-low: 1110).
- seg = '0' (active-low: 1000000).
- in_ready=1 once rst deasserts; busy=0.

FSM:
- IDLE: in_ready=1. Transfer occurs when in_valid&in_ready at a clk edge: load shift reg = in_value, clear 20-bit BCD accumulator (5 digits), step=0, go to CONV.
- CONV: 16 cycles. Each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd,shift} left by 1; step++. After step 15, go to LOAD.
- LOAD: 1 cycle. If BCD digit4 != 0 (value > 9999): ovf=1, all four display digits = dash code. Otherwise: ovf=0, display digits = BCD digits 3..0. Return to IDLE.
- Display register updates atomically in LOAD. The previous value keeps displaying throughout CONV.

Timing and handshake:
- Latency: transfer edge T; display register and ovf valid after edge T+17.
- in_ready=0 in CONV and LOAD; in_valid then is ignored (no queuing).
- Earliest next transfer is edge T+18.

Scan:
- Free-running counter 0..REFRESH_DIV-1, independent of FSM state.
- On wrap, digit index advances 0->1->2->3->0.
- seg/an are registered from the index, so they change one clk after the index.

Blanking and encoding:
- Leading-zero blanking: digits 3..1 are blanked (anode disabled) while they and every higher digit are 0. Digit 0 is always shown.
- Dash digits are never blanked.
- blank=1 forces all anodes inactive; seg still driven; scan keeps running.
- Digit codes, active-high {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, dash=1000000.
- seg is inverted when SEG_ACTIVE_LOW=1; an is inverted when AN_ACTIVE_LOW=1.

Reset mid-conversion:
- Aborts the conversion and returns to the reset state; the partial result is discarded.

Test Plan:
- Reset release, REFRESH_DIV=4 -> an cycles 1110 (only digit0 visible, others blanked, i.e. 1111), seg=1000000 on digit0, ovf=0, in_ready=1.
- Transfer 1234 at edge T -> busy T+1..T+17, in_ready=0 for same span; after T+17 display shows 1,2,3,4; scan with REFRESH_DIV=4 gives an 0111/1011/1101/1110 with seg 1111001/0100100/0110000/0011001 (active-low).
- Transfer 65535 -> ovf=1 after T+17; all four digits show 0111111 (active-low dash).
- Transfer 7 -> digits 3..1 anodes off; digit0 seg=1111000; ovf=0. Then transfer 9999 -> all digits 0010000.
- in_valid held high continuously with values 100 then 200 -> only 100 is accepted at T; 200 is accepted at T+18; display shows 100 until after T+17, then 200 after T+35.
- rst pulsed at T+8 during conversion of 4321 -> display remains 0, ovf=0, FSM IDLE; a new transfer of 42 then completes normally, displaying 42. Also: blank=1 at any time -> an=1111 within 1 clk.
